// File: rtl/bias1_sequencer_pkg.sv
// Shared definitions for the first-layer bias/ReLU sequencer: state
// encoding, default sizing and the activation-width helper.
package bias1_sequencer_pkg;

    // Default sizing of the first layer
    localparam int NWBITS_DEF     = 16;
    localparam int COUNT_BIT1_DEF = 10;
    localparam int N_NEURON_DEF   = 32;
    localparam int IDX_BITS_DEF   = 5;

    // Activation word grows by the accumulator guard bits
    function automatic int act_width(input int nwbits, input int count_bits);
        return nwbits + count_bits;
    endfunction

    localparam int ACT_W_DEF = NWBITS_DEF + COUNT_BIT1_DEF;

    // 3-bit state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_MAC_REQ   = 3'd1;
    localparam logic [2:0] ST_MAC_WAIT  = 3'd2;
    localparam logic [2:0] ST_BIAS      = 3'd3;
    localparam logic [2:0] ST_BIAS_WAIT = 3'd4;
    localparam logic [2:0] ST_WRITE     = 3'd5;
    localparam logic [2:0] ST_UPD       = 3'd6;
    localparam logic [2:0] ST_DONE      = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_MAC_REQ   = ST_MAC_REQ,
        S_MAC_WAIT  = ST_MAC_WAIT,
        S_BIAS      = ST_BIAS,
        S_BIAS_WAIT = ST_BIAS_WAIT,
        S_WRITE     = ST_WRITE,
        S_UPD       = ST_UPD,
        S_DONE      = ST_DONE
    } state_t;

endpackage

// File: rtl/bias1_sequencer_relu_clip.sv
// Combinational ReLU: negative inputs clamp to zero, zero and positive
// values pass through unchanged. Width-generic so later layers can reuse it.
module relu_clip #(
    parameter int W = 26
) (
    input  logic signed [W-1:0] din_i,
    output logic signed [W-1:0] dout_o
);

    // Sign bit alone decides the clamp
    always_comb begin
        dout_o = din_i;
        if (din_i[W-1]) begin
            dout_o = '0;
        end
    end

endmodule

// File: rtl/bias1_sequencer.sv
// Sequences the shared first-layer bias/ReLU unit over every hidden neuron.
// Forward sweep: MAC request -> wait -> bias add -> wait -> ReLU write, per
// neuron. Update sweep: one update_bias strobe per neuron on consecutive
// cycles. All strobes are flops loaded from the next state, so each output
// is a clean registered Moore output aligned with the state register.
module bias1_sequencer
    import bias1_sequencer_pkg::*;
#(
    parameter int NWBITS     = NWBITS_DEF,
    parameter int COUNT_BIT1 = COUNT_BIT1_DEF,
    parameter int N_NEURON   = N_NEURON_DEF,
    parameter int IDX_BITS   = IDX_BITS_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start_fwd,
    input  logic                                 start_update,
    input  logic                                 mac_done,
    input  logic                                 end_state1,
    input  logic signed [NWBITS+COUNT_BIT1-1:0]  before_relu,
    output logic                                 mac_start,
    output logic                                 add_bias,
    output logic                                 update_bias,
    output logic        [IDX_BITS-1:0]           neuron_idx,
    output logic                                 act_wr_en,
    output logic        [NWBITS+COUNT_BIT1-1:0]  act_data,
    output logic                                 busy,
    output logic                                 done
);

    localparam int ACT_W = act_width(NWBITS, COUNT_BIT1);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_NEURON - 1);
    localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);

    state_t                    state_q, state_d;
    logic [IDX_BITS-1:0]       idx_q, idx_d;
    logic [ACT_W-1:0]          act_q, act_d;
    logic signed [ACT_W-1:0]   relu_out;

    logic mac_start_q, add_bias_q, update_bias_q, act_wr_en_q, busy_q, done_q;

    relu_clip #(
        .W (ACT_W)
    ) u_relu_clip (
        .din_i  (before_relu),
        .dout_o (relu_out)
    );

    // Next-state, neuron index and activation capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        act_d   = act_q;
        unique case (state_q)
            S_IDLE: begin
                // Forward has priority; a coincident update request is dropped
                if (start_fwd) begin
                    idx_d   = '0;
                    state_d = S_MAC_REQ;
                end else if (start_update) begin
                    idx_d   = '0;
                    state_d = S_UPD;
                end
            end
            S_MAC_REQ: begin
                state_d = S_MAC_WAIT;
            end
            S_MAC_WAIT: begin
                if (mac_done) begin
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                state_d = S_BIAS_WAIT;
            end
            S_BIAS_WAIT: begin
                // Wait on the completion level rather than a fixed latency
                if (end_state1) begin
                    act_d   = relu_out;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_MAC_REQ;
                end
            end
            S_UPD: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, index, activation and strobe registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            act_q         <= '0;
            mac_start_q   <= 1'b0;
            add_bias_q    <= 1'b0;
            update_bias_q <= 1'b0;
            act_wr_en_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            act_q         <= act_d;
            mac_start_q   <= (state_d == S_MAC_REQ);
            add_bias_q    <= (state_d == S_BIAS);
            update_bias_q <= (state_d == S_UPD);
            act_wr_en_q   <= (state_d == S_WRITE);
            busy_q        <= (state_d != S_IDLE);
            done_q        <= (state_d == S_DONE);
        end
    end

    assign mac_start   = mac_start_q;
    assign add_bias    = add_bias_q;
    assign update_bias = update_bias_q;
    assign act_wr_en   = act_wr_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign neuron_idx  = idx_q;
    assign act_data    = act_q;

endmodule

// File: tb/tb_bias1_sequencer.sv
// Scoreboard bench for bias1_sequencer with a 4-neuron configuration.
// Stimulus pushes expected write/update/done events with their cycle
// numbers; a monitor pops and compares whenever the DUT presents one.
module tb_bias1_sequencer;

    localparam int NW  = 16;
    localparam int CB  = 10;
    localparam int NN  = 4;
    localparam int IB  = 2;
    localparam int AW  = NW + CB;

    localparam int K_WR   = 0;
    localparam int K_UPD  = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int     kind;
        int     idx;
        longint data;
        int     cyc;
    } exp_t;

    logic                 clk;
    logic                 reset;
    logic                 start_fwd;
    logic                 start_update;
    logic                 mac_done;
    logic                 end_state1;
    logic signed [AW-1:0] before_relu;
    logic                 mac_start;
    logic                 add_bias;
    logic                 update_bias;
    logic [IB-1:0]        neuron_idx;
    logic                 act_wr_en;
    logic [AW-1:0]        act_data;
    logic                 busy;
    logic                 done;

    logic mac_done_rsp, mac_done_noise;
    logic end_state1_rsp, end_state1_noise;

    assign mac_done   = mac_done_rsp | mac_done_noise;
    assign end_state1 = end_state1_rsp | end_state1_noise;

    exp_t sb[$];
    int   errs;
    int   checks;
    int   cyc;
    int   mac_cnt, add_cnt, upd_cnt, overlap_cnt;
    int   bias_tab [0:NN-1];
    int   mac_delay [0:NN-1];
    logic stall_en;
    int   stall_idx;

    bias1_sequencer #(
        .NWBITS     (NW),
        .COUNT_BIT1 (CB),
        .N_NEURON   (NN),
        .IDX_BITS   (IB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_fwd    (start_fwd),
        .start_update (start_update),
        .mac_done     (mac_done),
        .end_state1   (end_state1),
        .before_relu  (before_relu),
        .mac_start    (mac_start),
        .add_bias     (add_bias),
        .update_bias  (update_bias),
        .neuron_idx   (neuron_idx),
        .act_wr_en    (act_wr_en),
        .act_data     (act_data),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // MAC model: mac_done one cycle after mac_start plus a per-neuron delay
    initial begin
        int i;
        mac_done_rsp = 1'b0;
        forever begin
            @(negedge clk);
            if (mac_start) begin
                i = int'(neuron_idx);
                repeat (mac_delay[i]) @(posedge clk);
                @(posedge clk);
                #1 mac_done_rsp = 1'b1;
                @(posedge clk);
                #1 mac_done_rsp = 1'b0;
            end
        end
    end

    // Bias unit model: end_state1 with the tabulated sum one cycle after add_bias
    initial begin
        int i;
        end_state1_rsp = 1'b0;
        before_relu    = '0;
        forever begin
            @(negedge clk);
            if (add_bias) begin
                i = int'(neuron_idx);
                if (!(stall_en && i == stall_idx)) begin
                    @(posedge clk);
                    #1;
                    end_state1_rsp = 1'b1;
                    before_relu    = AW'(bias_tab[i]);
                    @(posedge clk);
                    #1 end_state1_rsp = 1'b0;
                end
            end
        end
    end

    // Monitor: counts strobes and checks every presented event against the scoreboard
    initial begin
        int   kind;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mac_start)   mac_cnt++;
            if (add_bias)    add_cnt++;
            if (update_bias) upd_cnt++;
            if (add_bias && update_bias) overlap_cnt++;
            if (act_wr_en || update_bias || done) begin
                kind = act_wr_en ? K_WR : (update_bias ? K_UPD : K_DONE);
                if (sb.size() == 0) begin
                    chk("unexpected_event_kind", kind, -1);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", kind, e.kind);
                    chk("event_cycle", cyc, e.cyc);
                    if (kind != K_DONE) chk("event_idx", neuron_idx, e.idx);
                    if (kind == K_WR)   chk("act_data", act_data, e.data);
                end
            end
        end
    end

    task automatic push(input int kind, input int idx, input longint data, input int c);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.data = data;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic set_tab(input int v0, input int v1, input int v2, input int v3);
        bias_tab[0] = v0;
        bias_tab[1] = v1;
        bias_tab[2] = v2;
        bias_tab[3] = v3;
    endtask

    // Expected forward sweep: 5 cycles per neuron plus extra MAC wait on one neuron
    task automatic push_fwd(input int t0, input int slow_idx, input int extra,
                            input int a0, input int a1, input int a2, input int a3);
        int acts [0:NN-1];
        int t;
        acts[0] = a0; acts[1] = a1; acts[2] = a2; acts[3] = a3;
        t = t0;
        for (int k = 0; k < NN; k++) begin
            t = t + 5 + ((k == slow_idx) ? extra : 0);
            push(K_WR, k, acts[k], t);
        end
        push(K_DONE, 0, 0, t + 1);
    endtask

    task automatic pulse_start(input logic fwd, input logic upd, output int t0);
        @(posedge clk);
        #1;
        start_fwd    = fwd;
        start_update = upd;
        t0 = cyc;
        @(posedge clk);
        #1;
        start_fwd    = 1'b0;
        start_update = 1'b0;
    endtask

    initial begin
        int t0;
        int m0, a0, u0;
        int found;
        errs = 0; checks = 0; cyc = 0;
        mac_cnt = 0; add_cnt = 0; upd_cnt = 0; overlap_cnt = 0;
        reset = 1'b1; start_fwd = 1'b0; start_update = 1'b0;
        mac_done_noise = 1'b0; end_state1_noise = 1'b0;
        stall_en = 1'b0; stall_idx = 0;
        for (int k = 0; k < NN; k++) begin
            mac_delay[k] = 0;
            bias_tab[k]  = 0;
        end

        // Reset: every output zero
        repeat (3) @(negedge clk);
        chk("reset_outputs", {mac_start, add_bias, update_bias, act_wr_en, busy, done,
                              neuron_idx, act_data}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Idle: stray mac_done/end_state1 pulses must not produce strobes
        m0 = mac_cnt; a0 = add_cnt; u0 = upd_cnt;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            mac_done_noise   = 1'($urandom_range(0, 1));
            end_state1_noise = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        mac_done_noise   = 1'b0;
        end_state1_noise = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_strobes", (mac_cnt - m0) + (add_cnt - a0) + (upd_cnt - u0), 0);
        chk("idle_busy", busy, 0);

        // Forward sweep, immediate responses, mixed-sign sums
        set_tab(300, -5, 0, -32768);
        m0 = mac_cnt; a0 = add_cnt;
        pulse_start(1'b1, 1'b0, t0);
        push_fwd(t0, -1, 0, 300, 0, 0, 0);
        wait_drain("fwd_drain");
        chk("fwd_mac_starts", mac_cnt - m0, NN);
        chk("fwd_add_bias", add_cnt - a0, NN);
        chk("fwd_act_hold", act_data, 0);

        // Forward sweep, neuron 2 MAC answers 7 cycles late
        set_tab(100, 200, -1, 7);
        mac_delay[2] = 7;
        m0 = mac_cnt;
        pulse_start(1'b1, 1'b0, t0);
        push_fwd(t0, 2, 7, 100, 200, 0, 7);
        wait_drain("slow_mac_drain");
        chk("slow_mac_starts", mac_cnt - m0, NN);
        chk("slow_act_hold", act_data, 7);
        mac_delay[2] = 0;

        // Update sweep: four consecutive strobes, done right after, no add_bias
        a0 = add_cnt; u0 = upd_cnt;
        pulse_start(1'b0, 1'b1, t0);
        for (int k = 0; k < NN; k++) push(K_UPD, k, 0, t0 + 1 + k);
        push(K_DONE, 0, 0, t0 + NN + 1);
        wait_drain("upd_drain");
        chk("upd_count", upd_cnt - u0, NN);
        chk("upd_no_add_bias", add_cnt - a0, 0);
        chk("upd_idx_back_to_0", neuron_idx, 0);

        // Simultaneous starts: forward wins; update held through busy and DONE is ignored
        set_tab(1, -2, 3, 4);
        u0 = upd_cnt;
        pulse_start(1'b1, 1'b1, t0);
        push_fwd(t0, -1, 0, 1, 0, 3, 4);
        while (cyc < t0 + 8) @(posedge clk);
        #1 start_update = 1'b1;
        while (cyc < t0 + 22) begin
            @(posedge clk);
            #1;
        end
        start_update = 1'b0;
        wait_drain("both_drain");
        repeat (4) @(negedge clk);
        chk("both_no_update", upd_cnt - u0, 0);
        chk("both_idle", busy, 0);

        // Reset while waiting on the bias unit for neuron 2
        set_tab(10, 20, 30, 40);
        stall_en  = 1'b1;
        stall_idx = 2;
        pulse_start(1'b1, 1'b0, t0);
        push(K_WR, 0, 10, t0 + 5);
        push(K_WR, 1, 20, t0 + 10);
        found = 0;
        for (int n = 0; n < 100 && found == 0; n++) begin
            @(negedge clk);
            if (add_bias && neuron_idx == 2'd2) found = 1;
        end
        chk("reach_bias_wait", found, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        stall_en = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {mac_start, add_bias, update_bias, act_wr_en, busy, done,
                              neuron_idx, act_data}, 0);
        chk("abort_queue", sb.size(), 0);
        repeat (10) @(negedge clk);

        // Fresh forward sweep after the abort
        set_tab(-7, 5, 1000, 0);
        pulse_start(1'b1, 1'b0, t0);
        push_fwd(t0, -1, 0, 0, 5, 1000, 0);
        wait_drain("after_abort_drain");

        chk("never_add_and_update", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
